// File: rtl/irq_request_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_request_ctrl_pkg : shared types and constants for the interrupt requester
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package irq_request_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } state_t;

   localparam int NUM_SRC = 4;

   // Byte offsets inside the 16-byte register window
   localparam logic [3:0] PEND_OFS = 4'h0;
   localparam logic [3:0] MASK_OFS = 4'h4;
   localparam logic [3:0] STAT_OFS = 4'h8;

   localparam int SRC_FACT = 0;
   localparam int SRC_MULT = 1;

   function automatic logic [NUM_SRC-1:0] idx_to_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_request_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_request_ctrl_if : CPU-side data bus and interrupt handshake bundle
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface irq_request_ctrl_if;

   logic        we;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        int_ack;
   logic        eoi;
   logic        done1;
   logic        done2;
   logic        done3;
   logic        done4;

   modport master (
      output we, addr, wd, int_ack, eoi,
      input  rd, done1, done2, done3, done4
   );

   modport slave (
      input  we, addr, wd, int_ack, eoi,
      output rd, done1, done2, done3, done4
   );

endinterface

`default_nettype wire

// File: rtl/irq_request_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc : 4-bit fixed-priority encoder, bit0 wins
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module irq_prio_enc
   import irq_request_ctrl_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [1:0]         idx
);

   // Scan from the top so the lowest set bit is the last one written
   always_comb begin
      valid = 1'b0;
      idx   = 2'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = i[1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/irq_request_ctrl.sv
// -----------------------------------------------------------------------------
// irq_request_ctrl : sticky-pending, maskable, fixed-priority interrupt requester
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module irq_request_ctrl
   import irq_request_ctrl_pkg::*;
#(
   parameter logic [31:0]        BASE_ADDR = 32'h0000_0B00,
   parameter logic [NUM_SRC-1:0] MASK_RST  = 4'hF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   irq_request_ctrl_if.slave  bus
);

   logic [NUM_SRC-1:0] r_prev_src;
   logic [NUM_SRC-1:0] r_pend;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_done;
   logic [1:0]         r_cur;
   state_t             r_state;

   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_elig;
   logic [NUM_SRC-1:0] w_done_nxt;
   logic [1:0]         w_cur_nxt;
   state_t             w_state_nxt;
   logic               w_sel;
   logic [1:0]         w_ofs;
   logic               w_pend_wr;
   logic               w_mask_wr;
   logic               w_ack;
   logic               w_win_valid;
   logic [1:0]         w_win_idx;
   logic [31:0]        w_rd;
   logic               w_unused_bits;

   // ---------------------------------------------------------------- decode
   assign w_sel     = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign w_ofs     = bus.addr[3:2];
   assign w_pend_wr = bus.we & w_sel & (w_ofs == PEND_OFS[3:2]);
   assign w_mask_wr = bus.we & w_sel & (w_ofs == MASK_OFS[3:2]);

   assign w_unused_bits = ^{bus.wd[31:NUM_SRC], bus.addr[1:0]};

   // ---------------------------------------------------------- pending logic
   assign w_rise = irq_src & ~r_prev_src;
   assign w_ack  = (r_state == ST_REQ) & bus.int_ack;

   // Clears are applied first so a same-cycle rise leaves the bit pending
   assign w_clr  = (w_pend_wr ? bus.wd[NUM_SRC-1:0] : '0)
                 | (w_ack ? idx_to_onehot(r_cur) : '0);
   assign w_elig = r_pend & r_mask;

   irq_prio_enc u_prio_enc (
      .req   (w_elig),
      .valid (w_win_valid),
      .idx   (w_win_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_src <= '0;
         r_pend     <= '0;
         r_mask     <= MASK_RST;
      end else begin
         r_prev_src <= irq_src;
         r_pend     <= (r_pend & ~w_clr) | w_rise;
         if (w_mask_wr) begin
            r_mask <= bus.wd[NUM_SRC-1:0];
         end
      end
   end

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cur   <= 2'd0;
         r_done  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Once in REQ the request is committed; mask changes cannot withdraw it
   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_done_nxt  = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_win_valid) begin
               w_state_nxt = ST_REQ;
               w_cur_nxt   = w_win_idx;
               w_done_nxt  = idx_to_onehot(w_win_idx);
            end
         end
         ST_REQ: begin
            if (bus.int_ack) begin
               w_state_nxt = ST_SERV;
            end else begin
               w_done_nxt  = idx_to_onehot(r_cur);
            end
         end
         ST_SERV: begin
            if (bus.eoi) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------- readback
   always_comb begin
      w_rd = '0;
      if (w_sel) begin
         case (w_ofs)
            PEND_OFS[3:2]: w_rd = {28'b0, r_pend};
            MASK_OFS[3:2]: w_rd = {28'b0, r_mask};
            STAT_OFS[3:2]: w_rd = {26'b0, r_state, 2'b00, r_cur};
            default:       w_rd = '0;
         endcase
      end
   end

   assign bus.rd    = w_rd;
   assign bus.done1 = r_done[0];
   assign bus.done2 = r_done[1];
   assign bus.done3 = r_done[2];
   assign bus.done4 = r_done[3];

endmodule

`default_nettype wire

// File: doc/irq_request_ctrl.md
Name: irq_request_ctrl

Overview:
- Source-side interrupt controller for the single-cycle MIPS vectored-interrupt scheme.
- Collects raw completion events from accelerator peripherals: factorial, multiplier, and two spares.
- Latches each event as sticky pending, applies a software mask, and picks one winner by fixed priority.
- Drives exactly one of done1..done4 to the CPU, holds it until int_ack, then blocks further requests until the ISR returns.
- Memory-mapped on the data bus, next to the peripheral register windows.

Parameters:
- BASE_ADDR, 32'h0000_0B00, base of the 16-byte register window; decode compares addr[31:4].
- MASK_RST, 4'hF, reset value of the MASK register (1 = source enabled).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_src  in  4  raw peripheral completion lines; bit0 = factorial, bit1 = multiplier, bits2-3 spare; level or pulse.
- int_ack  in  1  CPU interrupt acknowledge; high while the CPU accepts the vector.
- eoi  in  1  end-of-interrupt; CPU status_write strobe, high for the one cycle jepc executes.
- we  in  1  data-bus write enable.
- addr  in  32  data-bus byte address.
- wd  in  32  data-bus write data.
- rd  out  32  data-bus read data; combinational.
- done1, done2, done3, done4  out  1 each  registered request lines to the CPU; at most one high at a time.

Behaviour:
- Reset (asynchronous): prev_src=0, PEND=0, MASK=MASK_RST, cur=0, state=IDLE, done1..4=0.
- Edge detect: rise[i] = irq_src[i] & ~prev_src[i]; prev_src <= irq_src every cycle.
- PEND set: PEND[i] is set at the edge where rise[i] is sampled.
- PEND clear: PEND[i] is cleared by software W1C (write to PEND with wd[i]=1), or by the controller on acknowledge of source i.
- PEND priority: set beats clear in the same cycle, so the new event stays pending.
- Eligibility: elig = PEND & MASK. The winner is the lowest eligible index (bit0 highest priority).
- FSM IDLE: if elig != 0, latch cur = winner, go to REQ, and assert done[cur] on the same edge. Latency is rise sampled at edge k -> PEND at k -> done high at edge k+1.
- FSM REQ: hold done[cur] high.
  - On an edge with int_ack=1: clear PEND[cur] (subject to set-wins), drive done low, go to SERV.
  - Changing MASK during REQ does not withdraw the request; the request is committed.
- FSM SERV: done all low; new events only accumulate in PEND. On an edge with eoi=1, go to IDLE. Arbitration resumes the next cycle, so back-to-back ISRs are separated by at least one idle cycle.
- int_ack seen in IDLE or SERV is ignored. eoi seen in IDLE or REQ is ignored.
- Register map (sel = addr[31:4]==BASE_ADDR[31:4], word offset addr[3:2]):
  - 0x0 PEND: read {28'b0, PEND}; write is W1C on bits 3:0.
  - 0x4 MASK: read/write bits 3:0.
  - 0x8 STATUS: read-only {26'b0, state[1:0], 2'b0, cur[1:0]}. State encoding: IDLE=0, REQ=1, SERV=2.
  - 0xC: reads 0; writes ignored.
- rd = 0 when sel is 0. Register writes take effect at the clock edge when we & sel.
- Reset asserted mid-REQ or mid-SERV: immediate return to reset values; done drops asynchronously.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, REQ, SERV).
  - Register offsets (PEND_OFS=0x0, MASK_OFS=0x4, STAT_OFS=0x8).
  - Source index constants (SRC_FACT=0, SRC_MULT=1).
- One natural sub-module: irq_prio_enc, combinational 4-bit fixed-priority encoder producing {valid, idx[1:0]}.
- Edge detect, PEND/MASK registers, FSM and bus decode stay in the top module.

Test Plan:
- Single event: pulse irq_src=4'b0001 one cycle. Expect done1 high one edge later; hold int_ack 3 cycles in. Expect done1 still high until the ack edge, then low, STATUS=0x00000020 (SERV, cur=0), PEND=0. Pulse eoi -> STATUS=0.
- Priority: irq_src=4'b0110 in the same cycle. Expect done2 first; after ack+eoi, done3. PEND reads 0x4 while done2 is being serviced.
- Mask: write MASK=4'b1101, pulse source bit1. Expect PEND=0x2 and no done. Write MASK=0xF. Expect done2 one edge after the write.
- Level-held source: irq_src[0] held high 20 cycles. Expect exactly one PEND set and one done1 request. A re-assertion during SERV pends and produces a second done1 after eoi.
- Set-wins: rise on bit0 in the same cycle as the int_ack edge for cur=0, or the same cycle as a W1C of 0x1. Expect PEND[0]=1 afterward.
- Reset mid-REQ: assert reset while done4 is high. Expect done4=0 immediately, PEND=0, MASK=0xF, and no request after reset releases.
